// File: rtl/mulberry_bus_arb_rr.sv
// Round-robin crossbar arbiter: N masters -> M slaves (requests), M slaves -> N masters (responses).
// Latency: request grant is combinational; response strobe and error pulses follow one cycle after ack.
// Backpressure: a master holds until its ready; a busy slave only stalls its own masters; unacked slaves hold.
module mulberry_bus_arb_rr #(
    parameter int P_NUM_MASTERS = 4,
    parameter int P_NUM_SLAVES  = 4,
    parameter int P_BUS_DATA_W  = 32,
    parameter int P_MID_W       = $clog2(P_NUM_MASTERS + 1),
    parameter int P_SID_W       = $clog2(P_NUM_SLAVES + 1)
) (
    input  logic                               clk_ir,
    input  logic                               rst_il,
    input  logic [P_NUM_MASTERS*P_SID_W-1:0]   mst_sid_i,
    input  logic [P_NUM_MASTERS*P_BUS_DATA_W-1:0] mst_req_data_i,
    output logic [P_NUM_MASTERS-1:0]           mst_req_rdy_o,
    output logic [P_NUM_MASTERS-1:0]           mst_res_valid_o,
    output logic [P_BUS_DATA_W-1:0]            mst_res_o,
    input  logic [P_NUM_SLAVES-1:0]            slv_busy_i,
    output logic [P_BUS_DATA_W-1:0]            slv_req_data_o,
    output logic [P_NUM_SLAVES*P_MID_W-1:0]    slv_req_mid_o,
    input  logic [P_NUM_SLAVES*P_MID_W-1:0]    slv_rsp_mid_i,
    input  logic [P_NUM_SLAVES*P_BUS_DATA_W-1:0] slv_rsp_data_i,
    output logic [P_NUM_SLAVES-1:0]            slv_rsp_ack_o,
    output logic                               err_sid_o,
    output logic                               err_mid_o
);
    localparam int N    = P_NUM_MASTERS;
    localparam int M    = P_NUM_SLAVES;
    localparam int DW   = P_BUS_DATA_W;
    localparam int RP_W = (N > 1) ? $clog2(N) : 1;
    localparam int SP_W = (M > 1) ? $clog2(M) : 1;

    logic [RP_W-1:0]    req_ptr;
    logic [RP_W-1:0]    gnt_idx;
    logic [RP_W-1:0]    req_cand;
    logic [SP_W-1:0]    rsp_ptr;
    logic [SP_W-1:0]    ack_idx;
    logic [SP_W-1:0]    rsp_cand;
    logic [N-1:0]       req_elig;
    logic [M-1:0]       rsp_pend;
    logic               gnt_found;
    logic               gnt;
    logic               ack_found;
    logic               ack;
    logic               ack_ok;
    logic [P_SID_W-1:0] gnt_sid;
    logic [P_MID_W-1:0] ack_mid;
    logic [DW-1:0]      ack_data;
    int                 req_idx;
    int                 rsp_idx;

    // Invalid SIDs stay eligible so they get granted and flagged instead of stalling.
    always_comb begin
        req_elig = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if (mst_sid_i[i*P_SID_W +: P_SID_W] == P_SID_W'(j + 1) && !slv_busy_i[j])
                    req_elig[i] = 1'b1;
            end
            if (int'(mst_sid_i[i*P_SID_W +: P_SID_W]) > M)
                req_elig[i] = 1'b1;
        end
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_idx   = 0;
        req_cand  = '0;
        for (int k = 0; k < N; k++) begin
            req_idx = int'(req_ptr) + k;
            if (req_idx >= N)
                req_idx = req_idx - N;
            req_cand = RP_W'(req_idx);
            if (!gnt_found && req_elig[req_cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = req_cand;
            end
        end
        gnt     = gnt_found & rst_il;
        gnt_sid = mst_sid_i[int'(gnt_idx)*P_SID_W +: P_SID_W];
    end

    always_comb begin
        rsp_pend = '0;
        for (int j = 0; j < M; j++)
            rsp_pend[j] = |slv_rsp_mid_i[j*P_MID_W +: P_MID_W];
        ack_found = 1'b0;
        ack_idx   = '0;
        rsp_idx   = 0;
        rsp_cand  = '0;
        for (int k = 0; k < M; k++) begin
            rsp_idx = int'(rsp_ptr) + k;
            if (rsp_idx >= M)
                rsp_idx = rsp_idx - M;
            rsp_cand = SP_W'(rsp_idx);
            if (!ack_found && rsp_pend[rsp_cand]) begin
                ack_found = 1'b1;
                ack_idx   = rsp_cand;
            end
        end
        ack      = ack_found & rst_il;
        ack_mid  = slv_rsp_mid_i[int'(ack_idx)*P_MID_W +: P_MID_W];
        ack_data = slv_rsp_data_i[int'(ack_idx)*DW +: DW];
        ack_ok   = ack && (int'(ack_mid) <= N);
    end

    always_comb begin
        mst_req_rdy_o  = '0;
        slv_req_mid_o  = '0;
        slv_req_data_o = '0;
        slv_rsp_ack_o  = '0;
        if (gnt) begin
            mst_req_rdy_o[gnt_idx] = 1'b1;
            slv_req_data_o         = mst_req_data_i[int'(gnt_idx)*DW +: DW];
            for (int j = 0; j < M; j++) begin
                if (gnt_sid == P_SID_W'(j + 1))
                    slv_req_mid_o[j*P_MID_W +: P_MID_W] = P_MID_W'(gnt_idx) + P_MID_W'(1);
            end
        end
        if (ack)
            slv_rsp_ack_o[ack_idx] = 1'b1;
    end

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            req_ptr         <= '0;
            rsp_ptr         <= '0;
            mst_res_valid_o <= '0;
            mst_res_o       <= '0;
            err_sid_o       <= 1'b0;
            err_mid_o       <= 1'b0;
        end else begin
            err_sid_o <= gnt && (int'(gnt_sid) > M);
            err_mid_o <= ack && !ack_ok;
            for (int i = 0; i < N; i++)
                mst_res_valid_o[i] <= ack_ok && (ack_mid == P_MID_W'(i + 1));
            if (ack_ok)
                mst_res_o <= ack_data;
            if (gnt)
                req_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
            if (ack)
                rsp_ptr <= (int'(ack_idx) == M - 1) ? '0 : ack_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_mulberry_bus_arb_rr.sv
// Bench for mulberry_bus_arb_rr: directed scenarios then random traffic, checked by a queue scoreboard
// fed from a round-robin reference model; a negedge monitor pops whenever the DUT shows activity.
module tb_mulberry_bus_arb_rr;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int SW = 3;

    logic            clk_ir = 1'b0;
    logic            rst_il;
    logic [N*SW-1:0] mst_sid_i;
    logic [N*DW-1:0] mst_req_data_i;
    logic [N-1:0]    mst_req_rdy_o;
    logic [N-1:0]    mst_res_valid_o;
    logic [DW-1:0]   mst_res_o;
    logic [M-1:0]    slv_busy_i;
    logic [DW-1:0]   slv_req_data_o;
    logic [M*MW-1:0] slv_req_mid_o;
    logic [M*MW-1:0] slv_rsp_mid_i;
    logic [M*DW-1:0] slv_rsp_data_i;
    logic [M-1:0]    slv_rsp_ack_o;
    logic            err_sid_o;
    logic            err_mid_o;

    mulberry_bus_arb_rr #(
        .P_NUM_MASTERS(N), .P_NUM_SLAVES(M), .P_BUS_DATA_W(DW)
    ) dut (
        .clk_ir(clk_ir), .rst_il(rst_il),
        .mst_sid_i(mst_sid_i), .mst_req_data_i(mst_req_data_i),
        .mst_req_rdy_o(mst_req_rdy_o), .mst_res_valid_o(mst_res_valid_o), .mst_res_o(mst_res_o),
        .slv_busy_i(slv_busy_i), .slv_req_data_o(slv_req_data_o), .slv_req_mid_o(slv_req_mid_o),
        .slv_rsp_mid_i(slv_rsp_mid_i), .slv_rsp_data_i(slv_rsp_data_i), .slv_rsp_ack_o(slv_rsp_ack_o),
        .err_sid_o(err_sid_o), .err_mid_o(err_mid_o)
    );

    always #5 clk_ir = ~clk_ir;

    int cyc = 0;
    always @(posedge clk_ir) cyc <= cyc + 1;

    typedef struct { int cyc; logic [N-1:0] rdy; logic [M*MW-1:0] mid; logic [DW-1:0] data; } req_e_t;
    typedef struct { int cyc; logic [M-1:0] ack; } ack_e_t;
    typedef struct { int cyc; logic [N-1:0] vld; logic [DW-1:0] data; } res_e_t;
    typedef struct { int cyc; logic sid; logic mid; } err_e_t;

    req_e_t req_q[$];
    ack_e_t ack_q[$];
    res_e_t res_q[$];
    err_e_t err_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus state: what each master/slave is presenting this cycle.
    logic          rst_v;
    logic [2:0]    m_sid[N];
    logic [DW-1:0] m_dat[N];
    logic [M-1:0]  busy_v;
    logic [2:0]    s_mid[M];
    logic [DW-1:0] s_dat[M];
    logic [N-1:0]  granted;
    logic [M-1:0]  acked;
    int            md_rp = 0;
    int            md_sp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit eligible(input int i);
        int s;
        s = int'(m_sid[i]);
        return (s >= 1 && s <= M && !busy_v[s-1]) || (s > M);
    endfunction

    // Drive this cycle's inputs and predict every DUT reaction from the arbitration rules.
    task automatic apply_model();
        int w, s, k, i, mm;
        bit esid, emid;
        req_e_t re;
        ack_e_t ae;
        res_e_t rs;
        err_e_t ee;
        rst_il = rst_v;
        slv_busy_i = busy_v;
        for (i = 0; i < N; i++) begin
            mst_sid_i[i*SW +: SW]       = m_sid[i];
            mst_req_data_i[i*DW +: DW]  = m_dat[i];
        end
        for (i = 0; i < M; i++) begin
            slv_rsp_mid_i[i*MW +: MW]   = s_mid[i];
            slv_rsp_data_i[i*DW +: DW]  = s_dat[i];
        end
        granted = '0;
        acked   = '0;
        if (!rst_v) begin
            md_rp = 0;
            md_sp = 0;
            return;
        end
        esid = 0;
        emid = 0;
        w = -1;
        for (k = 0; k < N; k++) begin
            i = (md_rp + k) % N;
            if (w < 0 && eligible(i)) w = i;
        end
        if (w >= 0) begin
            re.cyc  = cyc;
            re.rdy  = N'(1) << w;
            re.mid  = '0;
            re.data = m_dat[w];
            if (int'(m_sid[w]) <= M) re.mid[(int'(m_sid[w]) - 1)*MW +: MW] = MW'(w + 1);
            else esid = 1;
            req_q.push_back(re);
            md_rp = (w + 1) % N;
            granted[w] = 1'b1;
        end
        s = -1;
        for (k = 0; k < M; k++) begin
            i = (md_sp + k) % M;
            if (s < 0 && s_mid[i] != 0) s = i;
        end
        if (s >= 0) begin
            ae.cyc = cyc;
            ae.ack = M'(1) << s;
            ack_q.push_back(ae);
            mm = int'(s_mid[s]);
            if (mm <= N) begin
                rs.cyc  = cyc + 1;
                rs.vld  = N'(1) << (mm - 1);
                rs.data = s_dat[s];
                res_q.push_back(rs);
            end else emid = 1;
            md_sp = (s + 1) % M;
            acked[s] = 1'b1;
        end
        if (esid || emid) begin
            ee.cyc = cyc + 1;
            ee.sid = esid;
            ee.mid = emid;
            err_q.push_back(ee);
        end
    endtask

    // mode 1: a granted master immediately re-requests the same slave with new data.
    task automatic post_update(input int mode);
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                if (mode == 1) m_dat[i] = $urandom;
                else m_sid[i] = 3'd0;
            end
        end
        for (int j = 0; j < M; j++)
            if (acked[j]) s_mid[j] = 3'd0;
    endtask

    task automatic step(input int mode);
        apply_model();
        @(posedge clk_ir);
        #1;
        post_update(mode);
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (m_sid[i] == 0 && $urandom_range(0, 2) != 0) begin
                m_sid[i] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
                m_dat[i] = $urandom;
            end
        end
        busy_v = M'($urandom & $urandom);
        for (int j = 0; j < M; j++) begin
            if (s_mid[j] == 0 && $urandom_range(0, 1) == 1) begin
                s_mid[j] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
                s_dat[j] = $urandom;
            end
        end
        rst_v = ($urandom_range(0, 199) != 0);
    endtask

    req_e_t mre;
    ack_e_t mae;
    res_e_t mrs;
    err_e_t mee;

    always @(negedge clk_ir) begin
        if (|mst_req_rdy_o || |slv_req_mid_o || |slv_req_data_o) begin
            chk("req_expected", req_q.size() != 0, 1);
            if (req_q.size() != 0) begin
                mre = req_q.pop_front();
                chk("req_cycle", cyc, mre.cyc);
                chk("req_rdy", mst_req_rdy_o, mre.rdy);
                chk("req_mid", slv_req_mid_o, mre.mid);
                chk("req_data", slv_req_data_o, mre.data);
            end
        end
        if (|slv_rsp_ack_o) begin
            chk("ack_expected", ack_q.size() != 0, 1);
            if (ack_q.size() != 0) begin
                mae = ack_q.pop_front();
                chk("ack_cycle", cyc, mae.cyc);
                chk("ack_vec", slv_rsp_ack_o, mae.ack);
            end
        end
        if (|mst_res_valid_o) begin
            chk("res_expected", res_q.size() != 0, 1);
            if (res_q.size() != 0) begin
                mrs = res_q.pop_front();
                chk("res_cycle", cyc, mrs.cyc);
                chk("res_valid", mst_res_valid_o, mrs.vld);
                chk("res_data", mst_res_o, mrs.data);
            end
        end
        if (err_sid_o || err_mid_o) begin
            chk("err_expected", err_q.size() != 0, 1);
            if (err_q.size() != 0) begin
                mee = err_q.pop_front();
                chk("err_cycle", cyc, mee.cyc);
                chk("err_sid", err_sid_o, mee.sid);
                chk("err_mid", err_mid_o, mee.mid);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        busy_v = '0;
        for (int i = 0; i < N; i++) begin m_sid[i] = 3'd0; m_dat[i] = '0; end
        for (int j = 0; j < M; j++) begin s_mid[j] = 3'd0; s_dat[j] = '0; end

        // Reset with live traffic presented: nothing may be granted or acked.
        rst_v = 1'b0;
        m_sid[0] = 3'd1; m_dat[0] = 32'h0000_1111;
        s_mid[0] = 3'd1; s_dat[0] = 32'h0000_2222;
        step(0);
        step(0);
        apply_model();
        #1;
        chk("rst_req_rdy", mst_req_rdy_o, 0);
        chk("rst_slv_mid", slv_req_mid_o, 0);
        chk("rst_slv_data", slv_req_data_o, 0);
        chk("rst_rsp_ack", slv_rsp_ack_o, 0);
        chk("rst_res_valid", mst_res_valid_o, 0);
        chk("rst_res_data", mst_res_o, 0);
        chk("rst_err_sid", err_sid_o, 0);
        chk("rst_err_mid", err_mid_o, 0);
        @(posedge clk_ir);
        #1;
        post_update(0);

        // Two masters on SID 1 alongside two simultaneous slave responses.
        rst_v = 1'b1;
        m_sid[2] = 3'd1; m_dat[2] = 32'h0000_3333;
        s_mid[0] = 3'd2; s_dat[0] = 32'hAAAA_0000;
        s_mid[2] = 3'd4; s_dat[2] = 32'hBBBB_0000;
        step(0);
        step(0);

        // Busy target must not block another master.
        m_sid[0] = 3'd2; m_dat[0] = 32'h0000_4444;
        m_sid[1] = 3'd3; m_dat[1] = 32'h0000_5555;
        busy_v = 4'b0010;
        step(0);
        step(0);
        busy_v = 4'b0000;
        apply_model();
        #1;
        chk("res_hold", mst_res_o, 32'hBBBB_0000);
        @(posedge clk_ir);
        #1;
        post_update(0);

        // Invalid SID is granted, drives no slave, flags err_sid.
        m_sid[3] = 3'd7; m_dat[3] = 32'h0000_7777;
        step(0);
        step(0);

        // All masters hammer SID 1: strict rotation.
        for (int i = 0; i < N; i++) begin m_sid[i] = 3'd1; m_dat[i] = $urandom; end
        for (int c = 0; c < 5; c++) step(1);
        for (int c = 0; c < 5; c++) step(0);

        // One-edge reset with pending traffic; both pointers must restart from 0.
        rst_v = 1'b0;
        m_sid[0] = 3'd2; m_dat[0] = 32'h0000_AAAA;
        m_sid[2] = 3'd2; m_dat[2] = 32'h0000_CCCC;
        s_mid[1] = 3'd1; s_dat[1] = 32'h1234_5678;
        s_mid[3] = 3'd2; s_dat[3] = 32'h8765_4321;
        step(0);
        rst_v = 1'b1;
        for (int c = 0; c < 5; c++) step(0);

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step(0);
        end

        rst_v = 1'b1;
        busy_v = '0;
        for (int c = 0; c < 12; c++) step(0);
        @(negedge clk_ir);
        #1;
        chk("req_q_drained", req_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
